// File: rtl/mailbox_pkg.sv
// mailbox_pkg: shared width and parameter-legality helpers for the mailbox FIFO
package mailbox_pkg;
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction
endpackage

// File: rtl/mailbox_regfile.sv
// mailbox_regfile: DEPTH x WIDTH storage, one synchronous write port (we/waddr/wdata) and one asynchronous read port (raddr/rdata)
module mailbox_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/mailbox_fifo.sv
// mailbox_fifo: FWFT mailbox FIFO; write side we/din/busy, read side re/dout/ready, status count/almost_full, sticky overflow/underflow cleared by clr_err
module mailbox_fifo
  import mailbox_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [WIDTH-1:0]       din,
  output logic                   busy,
  input  logic                   re,
  output logic [WIDTH-1:0]       dout,
  output logic                   ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);
  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL = CW'(AFULL_LEVEL);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("mailbox_fifo: DEPTH must be a power of two");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $error("mailbox_fifo: AFULL_LEVEL must be in 1..DEPTH");
  end

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d, ready_q, ready_d, afull_q, afull_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [WIDTH-1:0] hold_q, hold_d, rd_data;
  logic             wr_ok, rd_ok;

  // Flags come from count_d so they are registered yet already reflect this edge's traffic.
  always_comb begin
    wr_ok    = we & ~busy_q;
    rd_ok    = re & ready_q;
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(rd_ok);
    count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
    busy_d   = count_d == FULL;
    ready_d  = count_d != '0;
    afull_d  = count_d >= AFULL;
    ovf_d    = (we & busy_q) | (ovf_q & ~clr_err);
    unf_d    = (re & ~ready_q) | (unf_q & ~clr_err);
    hold_d   = rd_ok ? rd_data : hold_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      hold_q   <= hold_d;
    end
  end

  mailbox_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_regfile (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Storage is not reset, so an empty buffer shows the last popped word (zero after reset).
  assign dout        = ready_q ? rd_data : hold_q;
  assign busy        = busy_q;
  assign ready       = ready_q;
  assign count       = count_q;
  assign almost_full = afull_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
endmodule

// File: tb/tb_mailbox_fifo.sv
// tb_mailbox_fifo: scoreboard bench for mailbox_fifo against a queue-based reference model
module tb_mailbox_fifo;
  localparam int DEPTH = 4;
  localparam int AFULL_LEVEL = 3;

  logic       clk = 0, reset = 1, we = 0, re = 0, clr_err = 0;
  logic [7:0] din = 0, dout;
  logic       busy, ready, almost_full, overflow, underflow;
  logic [2:0] count;

  mailbox_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL_LEVEL)) dut (
    .clk(clk), .reset(reset), .we(we), .din(din), .busy(busy), .re(re),
    .dout(dout), .ready(ready), .count(count), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] last = 0;
  bit ovf = 0, unf = 0, started = 0;
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies the inputs that were present at the edge that just passed.
  task automatic step_model();
    bit full, empty;
    started = 1;
    if (reset) begin
      mq.delete();
      ovf = 0;
      unf = 0;
      last = 0;
      return;
    end
    full  = mq.size() == DEPTH;
    empty = mq.size() == 0;
    ovf = (we && full) || (ovf && !clr_err);
    unf = (re && empty) || (unf && !clr_err);
    if (re && !empty) last = mq.pop_front();
    if (we && !full) mq.push_back(din);
  endtask

  task automatic cyc(input bit w, input bit r, input logic [7:0] d, input bit c, input bit rs);
    @(posedge clk);
    #1;
    step_model();
    we = w;
    re = r;
    din = w ? d : 8'hxx;
    clr_err = c;
    reset = rs;
    if (!rs && r && mq.size() > 0) exp_q.push_back(mq[0]);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("ready", 32'(ready), 32'(mq.size() != 0));
      chk("busy", 32'(busy), 32'(mq.size() == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(mq.size() >= AFULL_LEVEL));
      chk("overflow", 32'(overflow), 32'(ovf));
      chk("underflow", 32'(underflow), 32'(unf));
      if (ready && mq.size() > 0) chk("dout_head", 32'(dout), 32'(mq[0]));
      if (!ready) chk("dout_hold", 32'(dout), 32'(last));
      if (!reset && re && ready) begin
        if (exp_q.size() == 0) chk("sb_underrun", 32'(1), 32'(0));
        else chk("dout_sb", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int pw, pr;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    // single word round trip
    cyc(1, 0, 8'hA5, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // fill, overflow, drain in order
    for (int i = 1; i <= 5; i++) cyc(1, 0, 8'(i), 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    // full with simultaneous write and read
    for (int i = 1; i <= 4; i++) cyc(1, 0, 8'(i), 0, 0);
    cyc(1, 1, 8'hEE, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    // empty with simultaneous write and read, then clear errors
    cyc(1, 1, 8'h5A, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    // streaming at count=2 across pointer wrap
    cyc(1, 0, 8'h0E, 0, 0);
    cyc(1, 0, 8'h0F, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 8'h10 + 8'(i), 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    // reset mid-operation
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'h30 + 8'(i), 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 8'h77, 0, 0);
    cyc(0, 1, 0, 0, 0);
    // randomized traffic with phases biased toward full and toward empty
    for (int i = 0; i < 800; i++) begin
      pw = ((i / 50) % 2 == 0) ? 75 : 30;
      pr = ((i / 50) % 2 == 0) ? 30 : 75;
      cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom),
          $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    end
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
